// File: rtl/bloom_if.sv
// Request/response bundle between the address decoder side and the bloom bit array.
// The decoder side (master) presents one request; the array (slave) reports completion, hit and count.
interface bloom_if #(
    parameter int SIZE = 16,
    parameter int K    = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            op;
    logic [K*SIZE-1:0]     decoder_out;
    logic                  done;
    logic                  hit;
    logic [7:0]            count;

    modport master (
        output in_valid, op, decoder_out,
        input  in_ready, done, hit, count
    );

    modport slave (
        input  in_valid, op, decoder_out,
        output in_ready, done, hit, count
    );
endinterface

// File: rtl/bloom_bit_array.sv
// K banks of SIZE membership bits; insert/query/clear walk the banks one per cycle.
// Returns a registered hit flag and a saturating count of distinct inserts.
module bloom_bit_array #(
    parameter int SIZE = 16,
    parameter int K    = 4
) (
    input  logic     clk,
    input  logic     rst,
    bloom_if.slave   bus
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_QRY = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [1:0]          op_q, op_d;
    logic [K*SIZE-1:0]   data_q, data_d;
    logic [SIZE-1:0]     bank_q [K];
    logic [SIZE-1:0]     bank_d [K];
    logic                hit_acc_q, hit_acc_d;
    logic                hit_q, hit_d;
    logic [7:0]          count_q, count_d;

    logic                accept_s;
    logic                last_s;
    logic [SIZE-1:0]     slice_s;
    logic                overlap_s;
    logic                ready_s;
    logic                done_s;

    assign accept_s  = bus.in_valid && (state_q == S_IDLE);
    assign last_s    = (idx_q == IW'(K - 1));
    assign slice_s   = data_q[int'(idx_q) * SIZE +: SIZE];
    assign overlap_s = |(bank_q[idx_q] & slice_s);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        ready_s = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            S_IDLE:  ready_s = 1'b1;
            S_DONE:  done_s  = 1'b1;
            default: begin
                ready_s = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    assign bus.in_ready = ready_s;
    assign bus.done     = done_s;
    assign bus.hit      = hit_q;
    assign bus.count    = count_q;

    // Datapath: latch request, update one bank per BUSY cycle, publish result entering DONE
    always_comb begin
        idx_d     = idx_q;
        op_d      = op_q;
        data_d    = data_q;
        bank_d    = bank_q;
        hit_acc_d = hit_acc_q;
        hit_d     = hit_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    op_d      = bus.op;
                    data_d    = bus.decoder_out;
                    idx_d     = {IW{1'b0}};
                    hit_acc_d = 1'b1;
                end else begin
                    idx_d     = idx_q;
                end
            end
            S_BUSY: begin
                // Insert checks membership against pre-insert contents, so hit means "already present"
                case (op_q)
                    OP_INS: begin
                        hit_acc_d     = hit_acc_q & overlap_s;
                        bank_d[idx_q] = bank_q[idx_q] | slice_s;
                    end
                    OP_QRY: hit_acc_d = hit_acc_q & overlap_s;
                    OP_CLR: begin
                        hit_acc_d     = 1'b0;
                        bank_d[idx_q] = {SIZE{1'b0}};
                    end
                    default: hit_acc_d = 1'b0;
                endcase
                if (last_s) begin
                    hit_d = hit_acc_d;
                    if (op_q == OP_CLR) begin
                        count_d = 8'd0;
                    end else if ((op_q == OP_INS) && !hit_acc_d && (count_q != 8'd255)) begin
                        count_d = count_q + 8'd1;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= {IW{1'b0}};
            op_q      <= 2'b00;
            data_q    <= {(K*SIZE){1'b0}};
            hit_acc_q <= 1'b0;
            hit_q     <= 1'b0;
            count_q   <= 8'd0;
            for (int i = 0; i < K; i++) begin
                bank_q[i] <= {SIZE{1'b0}};
            end
        end else begin
            idx_q     <= idx_d;
            op_q      <= op_d;
            data_q    <= data_d;
            hit_acc_q <= hit_acc_d;
            hit_q     <= hit_d;
            count_q   <= count_d;
            for (int i = 0; i < K; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end
endmodule

// File: tb/tb_bloom_bit_array.sv
// Directed bench for bloom_bit_array: insert/query/clear results, timing, back-to-back and async reset.
module tb_bloom_bit_array;
    localparam int SIZE = 16;
    localparam int K    = 4;

    localparam logic [1:0]  OP_INS = 2'b00;
    localparam logic [1:0]  OP_QRY = 2'b01;
    localparam logic [1:0]  OP_CLR = 2'b10;
    localparam logic [63:0] VEC_A  = 64'h4000_0800_0080_0008;
    localparam logic [63:0] VEC_A2 = 64'h4000_0800_0080_0004;
    localparam logic [63:0] VEC_Z2 = 64'h4000_0000_0080_0008;
    localparam logic [63:0] VEC_B  = 64'h0001_0001_0001_0001;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bloom_if #(.SIZE(SIZE), .K(K)) bus ();

    bloom_bit_array #(.SIZE(SIZE), .K(K)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from a negedge; after acceptance the inputs are scrambled to prove they were latched.
    task automatic issue(input logic [1:0] op_i, input logic [63:0] vec,
                         output int lat, output logic hit_o, output logic [7:0] cnt_o,
                         output int low_n, output int pulses);
        bit seen_ready;
        lat = -1; hit_o = 1'b0; cnt_o = 8'd0; low_n = 0; pulses = 0; seen_ready = 1'b0;
        bus.in_valid = 1'b1; bus.op = op_i; bus.decoder_out = vec;
        for (int w = 0; w < 20 && bus.in_ready !== 1'b1; w++) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.op = 2'b11; bus.decoder_out = {64{1'b1}};
        for (int s = 1; s <= 12; s++) begin
            if (bus.done === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = s; hit_o = bus.hit; cnt_o = bus.count;
                end
            end
            if (!seen_ready && bus.in_ready === 1'b0) low_n++;
            else seen_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = 2'b00; bus.decoder_out = 64'd0;
        repeat (3) @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
        checks++; if (bus.count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_insert();
        int lat, low_n, pulses; logic h; logic [7:0] c;
        issue(OP_INS, VEC_A, lat, h, c, low_n, pulses);
        checks++; if (lat !== 5) begin failures++; $display("FAIL ins_latency got=%0d exp=5", lat); end
        checks++; if (low_n !== 5) begin failures++; $display("FAIL ins_ready_low got=%0d exp=5", low_n); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL ins_pulses got=%0d exp=1", pulses); end
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL ins_hit got=%b exp=0", h); end
        checks++; if (c !== 8'd1) begin failures++; $display("FAIL ins_count got=%0d exp=1", c); end
        issue(OP_INS, VEC_A, lat, h, c, low_n, pulses);
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL reins_hit got=%b exp=1", h); end
        checks++; if (c !== 8'd1) begin failures++; $display("FAIL reins_count got=%0d exp=1", c); end
        checks++; if (bus.hit !== 1'b1) begin failures++; $display("FAIL reins_hit_held got=%b exp=1", bus.hit); end
    endtask

    task automatic test_query();
        int lat, low_n, pulses; logic h; logic [7:0] c;
        issue(OP_QRY, VEC_A, lat, h, c, low_n, pulses);
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL qry_a_hit got=%b exp=1", h); end
        checks++; if (c !== 8'd1) begin failures++; $display("FAIL qry_a_count got=%0d exp=1", c); end
        checks++; if (lat !== 5) begin failures++; $display("FAIL qry_latency got=%0d exp=5", lat); end
        issue(OP_QRY, VEC_A2, lat, h, c, low_n, pulses);
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL qry_bank0_miss got=%b exp=0", h); end
        issue(OP_QRY, VEC_Z2, lat, h, c, low_n, pulses);
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL qry_zero_slice got=%b exp=0", h); end
        checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL qry_hit_held got=%b exp=0", bus.hit); end
        issue(OP_QRY, VEC_A, lat, h, c, low_n, pulses);
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL qry_banks_kept got=%b exp=1", h); end
    endtask

    task automatic test_back_to_back();
        int done_n, done_t0, done_t1, acc_t; logic h1; logic [7:0] c1;
        done_n = 0; done_t0 = -1; done_t1 = -1; acc_t = -1; h1 = 1'b1; c1 = 8'd0;
        bus.in_valid = 1'b1; bus.op = OP_INS; bus.decoder_out = VEC_A;
        @(negedge clk);
        bus.decoder_out = VEC_B;
        for (int s = 1; s <= 20; s++) begin
            if (bus.done === 1'b1) begin
                done_n++;
                if (done_t0 < 0) done_t0 = s;
                else if (done_t1 < 0) begin done_t1 = s; h1 = bus.hit; c1 = bus.count; end
            end
            if (acc_t >= 0 && s > acc_t) bus.in_valid = 1'b0;
            if (acc_t < 0 && bus.in_ready === 1'b1 && bus.in_valid === 1'b1) acc_t = s;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (done_t0 !== 5) begin failures++; $display("FAIL b2b_first_done got=%0d exp=5", done_t0); end
        checks++; if (acc_t !== 6) begin failures++; $display("FAIL b2b_second_accept got=%0d exp=6", acc_t); end
        checks++; if (done_t1 !== 11) begin failures++; $display("FAIL b2b_second_done got=%0d exp=11", done_t1); end
        checks++; if (done_n !== 2) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=2", done_n); end
        checks++; if (h1 !== 1'b0) begin failures++; $display("FAIL b2b_b_hit got=%b exp=0", h1); end
        checks++; if (c1 !== 8'd2) begin failures++; $display("FAIL b2b_b_count got=%0d exp=2", c1); end
    endtask

    task automatic test_clear();
        int lat, low_n, pulses; logic h; logic [7:0] c;
        issue(OP_CLR, VEC_A, lat, h, c, low_n, pulses);
        checks++; if (pulses !== 1) begin failures++; $display("FAIL clr_pulses got=%0d exp=1", pulses); end
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL clr_hit got=%b exp=0", h); end
        checks++; if (c !== 8'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", c); end
        issue(OP_QRY, VEC_A, lat, h, c, low_n, pulses);
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL clr_then_qry got=%b exp=0", h); end
        issue(OP_QRY, VEC_B, lat, h, c, low_n, pulses);
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL clr_then_qry_b got=%b exp=0", h); end
    endtask

    task automatic test_reset_mid_busy();
        int lat, low_n, pulses, done_n; logic h; logic [7:0] c;
        issue(OP_INS, VEC_A, lat, h, c, low_n, pulses);
        checks++; if (c !== 8'd1) begin failures++; $display("FAIL rmb_pre_count got=%0d exp=1", c); end
        bus.in_valid = 1'b1; bus.op = OP_INS; bus.decoder_out = VEC_B;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.count !== 8'd0) begin failures++; $display("FAIL rmb_count got=%0d exp=0", bus.count); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rmb_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int s = 0; s < 10; s++) begin
            if (bus.done === 1'b1) done_n++;
            @(negedge clk);
        end
        checks++; if (done_n !== 0) begin failures++; $display("FAIL rmb_no_done got=%0d exp=0", done_n); end
        issue(OP_QRY, VEC_A, lat, h, c, low_n, pulses);
        checks++; if (h !== 1'b0) begin failures++; $display("FAIL rmb_qry_a got=%b exp=0", h); end
        checks++; if (c !== 8'd0) begin failures++; $display("FAIL rmb_qry_count got=%0d exp=0", c); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_insert();
        test_query();
        test_back_to_back();
        test_clear();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
